// File: rtl/regfile_wb_ctrl.sv
// Register-file writeback controller: clears the regfile after reset, then merges
// load returns and ALU results onto one write port while tracking pending loads.
module regfile_wb_ctrl (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        alu_wb_valid,
    input  logic [4:0]  alu_wb_rd,
    input  logic        alu_wb_long,
    input  logic [63:0] alu_wb_data,
    output logic        alu_wb_ready,
    input  logic        dcache_ack_valid,
    input  logic [4:0]  dcache_ack_rd,
    input  logic [63:0] dcache_ack_data,
    output logic        dcache_ack_retry,
    input  logic        load_issue_valid,
    input  logic [4:0]  load_issue_rd,
    input  logic [4:0]  rs1_sel,
    input  logic [4:0]  rs2_sel,
    output logic        rs1_busy,
    output logic        rs2_busy,
    output logic        rf_wr_en,
    output logic        rf_wr_long,
    output logic [4:0]  rf_wr_rd,
    output logic [63:0] rf_wr_data,
    output logic        init_done
);

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    state_e      state_q, state_d;
    logic [4:0]  sweep_q, sweep_d;
    logic [31:0] busy_q, busy_d;
    logic        wr_en_q, wr_en_d;
    logic        wr_long_q, wr_long_d;
    logic [4:0]  wr_rd_q, wr_rd_d;
    logic [63:0] wr_data_q, wr_data_d;
    logic        run_s;
    logic        ack_acc_s;
    logic [31:0] set_mask_s;
    logic [31:0] clr_mask_s;

    assign run_s     = (state_q == ST_RUN);
    // Load returns always win the port; the ALU is stalled while one is presented.
    assign ack_acc_s = run_s && dcache_ack_valid;

    assign alu_wb_ready     = run_s && !dcache_ack_valid;
    assign dcache_ack_retry = !run_s;
    assign init_done        = run_s;

    assign rs1_busy = (rs1_sel != 5'd0) && busy_q[rs1_sel];
    assign rs2_busy = (rs2_sel != 5'd0) && busy_q[rs2_sel];

    assign rf_wr_en   = wr_en_q;
    assign rf_wr_long = wr_long_q;
    assign rf_wr_rd   = wr_rd_q;
    assign rf_wr_data = wr_data_q;

    // Next state and clear-sweep counter.
    always_comb begin
        state_d = state_q;
        sweep_d = sweep_q;
        case (state_q)
            ST_INIT: begin
                sweep_d = sweep_q + 5'd1;
                if (sweep_q == 5'd31) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_INIT;
                end
            end
            ST_RUN: begin
                state_d = ST_RUN;
                sweep_d = 5'd0;
            end
            default: begin
                state_d = ST_INIT;
                sweep_d = 5'd0;
            end
        endcase
    end

    // Next value of the registered regfile write port.
    always_comb begin
        wr_en_d   = 1'b0;
        wr_long_d = wr_long_q;
        wr_rd_d   = wr_rd_q;
        wr_data_d = wr_data_q;
        case (state_q)
            ST_INIT: begin
                wr_en_d   = 1'b1;
                wr_long_d = 1'b1;
                wr_rd_d   = sweep_q;
                wr_data_d = 64'd0;
            end
            ST_RUN: begin
                // x0 writes are consumed but never reach the regfile.
                if (dcache_ack_valid) begin
                    wr_en_d   = (dcache_ack_rd != 5'd0);
                    wr_long_d = 1'b1;
                    wr_rd_d   = dcache_ack_rd;
                    wr_data_d = dcache_ack_data;
                end else if (alu_wb_valid) begin
                    wr_en_d   = (alu_wb_rd != 5'd0);
                    wr_long_d = alu_wb_long;
                    wr_rd_d   = alu_wb_rd;
                    wr_data_d = alu_wb_data;
                end else begin
                    wr_en_d   = 1'b0;
                end
            end
            default: begin
                wr_en_d = 1'b0;
            end
        endcase
    end

    // Scoreboard update; a new issue overrides a same-cycle return to the same rd.
    always_comb begin
        set_mask_s = 32'd0;
        clr_mask_s = 32'd0;
        if (ack_acc_s) begin
            clr_mask_s[dcache_ack_rd] = 1'b1;
        end else begin
            clr_mask_s = 32'd0;
        end
        if (run_s && load_issue_valid && (load_issue_rd != 5'd0)) begin
            set_mask_s[load_issue_rd] = 1'b1;
        end else begin
            set_mask_s = 32'd0;
        end
        busy_d    = (busy_q & ~clr_mask_s) | set_mask_s;
        busy_d[0] = 1'b0;
    end

    // FSM state and sweep counter registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_INIT;
            sweep_q <= 5'd0;
        end else begin
            state_q <= state_d;
            sweep_q <= sweep_d;
        end
    end

    // Registered regfile write port.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_en_q   <= 1'b0;
            wr_long_q <= 1'b0;
            wr_rd_q   <= 5'd0;
            wr_data_q <= 64'd0;
        end else begin
            wr_en_q   <= wr_en_d;
            wr_long_q <= wr_long_d;
            wr_rd_q   <= wr_rd_d;
            wr_data_q <= wr_data_d;
        end
    end

    // Pending-load busy bits.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy_q <= 32'd0;
        end else begin
            busy_q <= busy_d;
        end
    end

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Directed bench for regfile_wb_ctrl: clear sweep, ack/ALU arbitration, scoreboard, resets.
module tb_regfile_wb_ctrl;

    logic        clk;
    logic        reset_n;
    logic        alu_wb_valid;
    logic [4:0]  alu_wb_rd;
    logic        alu_wb_long;
    logic [63:0] alu_wb_data;
    logic        alu_wb_ready;
    logic        dcache_ack_valid;
    logic [4:0]  dcache_ack_rd;
    logic [63:0] dcache_ack_data;
    logic        dcache_ack_retry;
    logic        load_issue_valid;
    logic [4:0]  load_issue_rd;
    logic [4:0]  rs1_sel;
    logic [4:0]  rs2_sel;
    logic        rs1_busy;
    logic        rs2_busy;
    logic        rf_wr_en;
    logic        rf_wr_long;
    logic [4:0]  rf_wr_rd;
    logic [63:0] rf_wr_data;
    logic        init_done;

    int tests_run;
    int tests_failed;

    regfile_wb_ctrl dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .alu_wb_valid     (alu_wb_valid),
        .alu_wb_rd        (alu_wb_rd),
        .alu_wb_long      (alu_wb_long),
        .alu_wb_data      (alu_wb_data),
        .alu_wb_ready     (alu_wb_ready),
        .dcache_ack_valid (dcache_ack_valid),
        .dcache_ack_rd    (dcache_ack_rd),
        .dcache_ack_data  (dcache_ack_data),
        .dcache_ack_retry (dcache_ack_retry),
        .load_issue_valid (load_issue_valid),
        .load_issue_rd    (load_issue_rd),
        .rs1_sel          (rs1_sel),
        .rs2_sel          (rs2_sel),
        .rs1_busy         (rs1_busy),
        .rs2_busy         (rs2_busy),
        .rf_wr_en         (rf_wr_en),
        .rf_wr_long       (rf_wr_long),
        .rf_wr_rd         (rf_wr_rd),
        .rf_wr_data       (rf_wr_data),
        .init_done        (init_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_wr(input string tag, input logic en, input logic lng,
                            input logic [4:0] rd, input logic [63:0] data);
        check({tag, "_en"},   {63'd0, rf_wr_en},   {63'd0, en});
        check({tag, "_long"}, {63'd0, rf_wr_long}, {63'd0, lng});
        check({tag, "_rd"},   {59'd0, rf_wr_rd},   {59'd0, rd});
        check({tag, "_data"}, rf_wr_data, data);
    endtask

    task automatic sweep(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            check_wr("sweep", 1'b1, 1'b1, i[4:0], 64'd0);
            if (i < 31) begin
                check("sweep_init_done", {63'd0, init_done}, 64'd0);
            end
        end
    endtask

    initial begin
        tests_run        = 0;
        tests_failed     = 0;
        reset_n          = 1'b1;
        alu_wb_valid     = 1'b0;
        alu_wb_rd        = 5'd0;
        alu_wb_long      = 1'b0;
        alu_wb_data      = 64'd0;
        dcache_ack_valid = 1'b0;
        dcache_ack_rd    = 5'd0;
        dcache_ack_data  = 64'd0;
        load_issue_valid = 1'b0;
        load_issue_rd    = 5'd0;
        rs1_sel          = 5'd0;
        rs2_sel          = 5'd0;

        #2 reset_n = 1'b0;
        #1;
        check_wr("reset", 1'b0, 1'b0, 5'd0, 64'd0);
        tick();
        check("reset_init_done", {63'd0, init_done}, 64'd0);
        check("reset_ready", {63'd0, alu_wb_ready}, 64'd0);
        check("reset_retry", {63'd0, dcache_ack_retry}, 64'd1);

        // Sweep with a load issue and an ack presented; both must be ignored.
        @(negedge clk);
        reset_n          = 1'b1;
        load_issue_valid = 1'b1;
        load_issue_rd    = 5'd4;
        rs1_sel          = 5'd4;
        dcache_ack_valid = 1'b1;
        dcache_ack_rd    = 5'd4;
        dcache_ack_data  = 64'h5555;
        alu_wb_valid     = 1'b1;
        alu_wb_rd        = 5'd2;
        #1;
        check("init_retry", {63'd0, dcache_ack_retry}, 64'd1);
        check("init_ready", {63'd0, alu_wb_ready}, 64'd0);
        sweep(32);
        load_issue_valid = 1'b0;
        dcache_ack_valid = 1'b0;
        alu_wb_valid     = 1'b0;
        tick();
        check("run_init_done", {63'd0, init_done}, 64'd1);
        check("run_ready", {63'd0, alu_wb_ready}, 64'd1);
        check("run_retry", {63'd0, dcache_ack_retry}, 64'd0);
        check("init_issue_ignored", {63'd0, rs1_busy}, 64'd0);
        check_wr("run_idle", 1'b0, 1'b1, 5'd31, 64'd0);

        // Ack and ALU collide: ack first, ALU the cycle after.
        dcache_ack_valid = 1'b1;
        dcache_ack_rd    = 5'd5;
        dcache_ack_data  = 64'hAA;
        alu_wb_valid     = 1'b1;
        alu_wb_rd        = 5'd6;
        alu_wb_long      = 1'b1;
        alu_wb_data      = 64'h66;
        #1;
        check("collide_ready", {63'd0, alu_wb_ready}, 64'd0);
        tick();
        check_wr("ack5", 1'b1, 1'b1, 5'd5, 64'hAA);
        dcache_ack_valid = 1'b0;
        #1;
        check("alu_ready_after", {63'd0, alu_wb_ready}, 64'd1);
        tick();
        check_wr("alu6", 1'b1, 1'b1, 5'd6, 64'h66);
        alu_wb_valid = 1'b0;
        tick();
        check_wr("idle_hold", 1'b0, 1'b1, 5'd6, 64'h66);

        // Scoreboard set then clear.
        load_issue_valid = 1'b1;
        load_issue_rd    = 5'd7;
        rs1_sel          = 5'd7;
        rs2_sel          = 5'd7;
        #1;
        check("busy7_before", {63'd0, rs1_busy}, 64'd0);
        tick();
        load_issue_valid = 1'b0;
        check("busy7_rs1", {63'd0, rs1_busy}, 64'd1);
        check("busy7_rs2", {63'd0, rs2_busy}, 64'd1);
        dcache_ack_valid = 1'b1;
        dcache_ack_rd    = 5'd7;
        dcache_ack_data  = 64'h77;
        #1;
        check("busy7_ack_cycle", {63'd0, rs1_busy}, 64'd1);
        tick();
        dcache_ack_valid = 1'b0;
        check("busy7_cleared", {63'd0, rs1_busy}, 64'd0);
        check_wr("ack7", 1'b1, 1'b1, 5'd7, 64'h77);

        // Same-cycle issue and ack of rd 9: set wins, data still written.
        load_issue_valid = 1'b1;
        load_issue_rd    = 5'd9;
        dcache_ack_valid = 1'b1;
        dcache_ack_rd    = 5'd9;
        dcache_ack_data  = 64'h99;
        rs2_sel          = 5'd9;
        tick();
        load_issue_valid = 1'b0;
        dcache_ack_valid = 1'b0;
        check("busy9_set_wins", {63'd0, rs2_busy}, 64'd1);
        check_wr("ack9", 1'b1, 1'b1, 5'd9, 64'h99);

        // ALU write to busy rd 9 goes through without touching busy.
        alu_wb_valid = 1'b1;
        alu_wb_rd    = 5'd9;
        alu_wb_long  = 1'b0;
        alu_wb_data  = 64'h1234;
        tick();
        alu_wb_valid = 1'b0;
        check_wr("alu9_busy", 1'b1, 1'b0, 5'd9, 64'h1234);
        check("busy9_kept", {63'd0, rs2_busy}, 64'd1);

        // Ack for a non-busy rd is still written.
        dcache_ack_valid = 1'b1;
        dcache_ack_rd    = 5'd12;
        dcache_ack_data  = 64'hC0FFEE;
        tick();
        dcache_ack_valid = 1'b0;
        check_wr("ack12_nonbusy", 1'b1, 1'b1, 5'd12, 64'hC0FFEE);

        // x0: ALU write suppressed, issue to x0 ignored, rs=0 never busy.
        alu_wb_valid     = 1'b1;
        alu_wb_rd        = 5'd0;
        alu_wb_long      = 1'b1;
        alu_wb_data      = 64'hFF;
        load_issue_valid = 1'b1;
        load_issue_rd    = 5'd0;
        rs1_sel          = 5'd0;
        #1;
        check("alu0_ready", {63'd0, alu_wb_ready}, 64'd1);
        tick();
        load_issue_valid = 1'b0;
        check("alu0_en", {63'd0, rf_wr_en}, 64'd0);
        check("rs0_busy", {63'd0, rs1_busy}, 64'd0);
        alu_wb_rd   = 5'd3;
        alu_wb_long = 1'b0;
        alu_wb_data = 64'h33;
        tick();
        alu_wb_valid = 1'b0;
        check_wr("alu3_short", 1'b1, 1'b0, 5'd3, 64'h33);

        // Ack to x0 is consumed without a write.
        dcache_ack_valid = 1'b1;
        dcache_ack_rd    = 5'd0;
        dcache_ack_data  = 64'hDEAD;
        tick();
        dcache_ack_valid = 1'b0;
        check("ack0_en", {63'd0, rf_wr_en}, 64'd0);

        // Reset from RUN, then reset again at sweep index 17.
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check_wr("run_reset", 1'b0, 1'b0, 5'd0, 64'd0);
        check("run_reset_busy", {63'd0, rs2_busy}, 64'd0);
        check("run_reset_done", {63'd0, init_done}, 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        sweep(18);
        #2 reset_n = 1'b0;
        #1;
        check_wr("mid_reset", 1'b0, 1'b0, 5'd0, 64'd0);
        check("mid_reset_done", {63'd0, init_done}, 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        sweep(32);
        tick();
        check("resweep_done", {63'd0, init_done}, 64'd1);
        check("resweep_idle", {63'd0, rf_wr_en}, 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
